// File: rtl/scope_acq.sv
// Scope acquisition controller: frames the sample stream as pre-trigger, armed and post-trigger phases.
// Optional SCOPE_ACQ_TIMESTAMP_EN adds a free-running cycle counter latched into sts_tsp on trigger accept.
module scope_acq #(
    parameter int DWI = 14,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctl_rst,
    input  logic           ctl_acq,
    input  logic           ctl_stp,
    input  logic [CW-1:0]  cfg_pre,
    input  logic [CW-1:0]  cfg_pst,
    input  logic           trg,
    output logic           sts_acq,
    output logic           sts_arm,
    output logic           sts_trg,
    output logic [CW-1:0]  sts_pre,
    output logic [CW-1:0]  sts_pst,
    input  logic [DWI-1:0] sti_tdata,
    input  logic           sti_tvalid,
    output logic           sti_tready,
    output logic [DWI-1:0] sto_tdata,
    output logic           sto_tvalid,
    input  logic           sto_tready,
    output logic           sto_tlast
`ifdef SCOPE_ACQ_TIMESTAMP_EN
    ,
    output logic [63:0]    sts_tsp
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARM, S_POST} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  pre_q, pre_d, pst_q, pst_d;
    logic           trg_q, trg_d;
    logic [DWI-1:0] tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d, tlast_q, tlast_d;

    logic           clr, xi, active, fin, trg_acc;
    logic [CW:0]    pre_sum, pst_sum;
    logic [CW-1:0]  pst_lim;

    assign clr        = rst | ctl_rst;
    assign sti_tready = ~tvalid_q | sto_tready;
    assign xi         = sti_tvalid & sti_tready;
    assign active     = (state_q != S_IDLE);
    assign pre_sum    = {1'b0, pre_q} + {{CW{1'b0}}, xi};
    assign pst_sum    = {1'b0, pst_q} + {{CW{1'b0}}, xi};
    // A post count of zero still frames one sample so TLAST always appears.
    assign pst_lim    = (cfg_pst == '0) ? {{(CW-1){1'b0}}, 1'b1} : cfg_pst;
    assign fin        = (state_q == S_POST) & xi & ~ctl_stp & (pst_sum >= {1'b0, pst_lim});
    assign trg_acc    = (state_q == S_ARM) & trg & ~ctl_stp;

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        pst_d    = pst_q;
        trg_d    = trg_acc;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;

        if (active && !(&pre_q))
            pre_d = pre_sum[CW-1:0];

        case (state_q)
            S_IDLE: begin
                if (ctl_acq && !ctl_stp) begin
                    pre_d   = '0;
                    pst_d   = '0;
                    state_d = (cfg_pre == '0) ? S_ARM : S_PRE;
                end
            end
            S_PRE: begin
                if (pre_sum >= {1'b0, cfg_pre})
                    state_d = S_ARM;
            end
            S_ARM: begin
                if (trg)
                    state_d = S_POST;
            end
            S_POST: begin
                pst_d = pst_sum[CW-1:0];
                if (fin)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Stop overrides every transition; the registered word is left to drain.
        if (active && ctl_stp)
            state_d = S_IDLE;

        if (xi) begin
            tdata_d  = sti_tdata;
            tvalid_d = active;
            tlast_d  = fin;
        end else if (sto_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            pst_q    <= '0;
            trg_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            pst_q    <= pst_d;
            trg_q    <= trg_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign sts_acq    = active;
    assign sts_arm    = (state_q == S_ARM);
    assign sts_trg    = trg_q;
    assign sts_pre    = pre_q;
    assign sts_pst    = pst_q;
    assign sto_tdata  = tdata_q;
    assign sto_tvalid = tvalid_q;
    assign sto_tlast  = tlast_q;

`ifdef SCOPE_ACQ_TIMESTAMP_EN
    logic [63:0] cyc_q, cyc_d, tsp_q, tsp_d;

    always_comb begin
        cyc_d = cyc_q + 64'd1;
        tsp_d = trg_acc ? cyc_q : tsp_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cyc_q <= '0;
            tsp_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            tsp_q <= tsp_d;
        end
    end

    assign sts_tsp = tsp_q;
`endif

endmodule
